window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Producer side of the 3x3 window interface: turns a raster-order pixel stream into `window_valid` / `window_flat` for the blur and Sobel stages.
- Stores two previous lines in line buffers (BSRAM-friendly, synchronous read) and keeps a 3x3 shift register.
- Emits one window per interior pixel, with frame position tracking and resync on `frame_start`.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- IMG_WIDTH, 640, pixels per line (>=3).
- IMG_HEIGHT, 480, lines per frame (>=3).
- COL_BITS, 10, column counter width (>= clog2(IMG_WIDTH)).
- ROW_BITS, 9, row counter width (>= clog2(IMG_HEIGHT)).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- pixel_valid  input  1  `pixel_in` is accepted this cycle. There is no backpressure.
- pixel_in  input  PIXEL_WIDTH  incoming pixel, raster order.
- frame_start  input  1  qualified by `pixel_valid`; marks this pixel as (row 0, col 0).
- window_valid  output  1  `window_flat` holds a complete window this cycle.
- window_flat  output  PIXEL_WIDTH*9  slot k at bits [PIXEL_WIDTH*k +: PIXEL_WIDTH]; k = 3*wr + wc, with wr=0 the oldest row and wc=0 the leftmost column.
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame.
- resync_err  output  1  one-cycle pulse when `frame_start` arrives while not at (0,0).

Behaviour:
- Reset (rst=1 at posedge): the following clear to 0.
  - Outputs: `window_valid`, `window_flat`, `frame_done`, `resync_err`.
  - Internal: col/row counters, pipeline valids.
  - Line-buffer RAM contents are not cleared; stale data is masked by the row/col qualification.
  - Reset asserted mid-frame aborts the frame. The next accepted pixel is treated as (0,0) whether or not `frame_start` is set.
- Counters advance only on `pixel_valid`.
  - col increments; at IMG_WIDTH-1 it wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
- When `frame_start` & `pixel_valid`, the pixel is placed at (0,0) and the counters continue from there.
  - If the counters did not already point at (0,0), `resync_err` pulses on the next cycle, with the same timing as a stage-1 register.
- Pipeline, fixed 2-cycle latency:
  - Pixel accepted at cycle N. Stage 1 (N+1) registers pixel, position and line-buffer reads for that column.
  - Stage 2 (N+2) shifts the new column into the window and drives `window_valid`.
- Gaps in `pixel_valid` propagate as gaps in `window_valid`. The window shift register and line buffers do not change on invalid cycles.
- Line buffers: lb1 holds row r-1 and lb0 holds row r-2, both addressed by col.
  - On an accepted pixel at col c: read lb1[c] and lb0[c], then write lb1[c] <= pixel and lb0[c] <= old lb1[c].
  - Read-before-write is required at the same address.
- Window contents for a pixel accepted at (r,c), with P(y,x) the pixel at row y, column x:
  - slot 8 = P(r,c), slot 7 = P(r,c-1), slot 6 = P(r,c-2)
  - slot 5 = P(r-1,c), slot 4 = P(r-1,c-1), slot 3 = P(r-1,c-2)
  - slot 2 = P(r-2,c), slot 1 = P(r-2,c-1), slot 0 = P(r-2,c-2)
  - The window centre is (r-1,c-1).
- `window_valid` is 1 at N+2 iff r>=2 and c>=2.
  - No border padding.
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
  - Columns 0/1 of each row prime the shift register without output, so there is no cross-line contamination.
- `window_flat` holds its last value when `window_valid`=0. Its value is don't-care for checking while invalid.
- `frame_done` = `window_valid` & (r==IMG_HEIGHT-1) & (c==IMG_WIDTH-1) for the corresponding pixel.
- Simultaneous `frame_start` and rst: rst wins.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, PIXEL_WIDTH=8, pixel value = 16*r+c):
- Continuous frame with `frame_start` on the first pixel:
  - 24 windows.
  - First window 2 cycles after pixel (2,2), with slot0=0x00, slot4=0x11, slot8=0x22.
  - Last window has slot8=0x57, and `frame_done`=1 on that cycle only.
- Random `pixel_valid` gaps (~40% idle) -> same 24 windows with identical contents in the same order; each `window_valid` exactly 2 cycles after its pixel.
- Two back-to-back frames (second has values +0x80) -> window 1 of frame 2 has slot0=0x80, slot8=0xA2. No stale frame-1 data in any valid window; no `resync_err`.
- `frame_start` asserted at pixel (3,4) of frame 1 -> `resync_err` pulses once. Next window appears only after new (2,2), with slot0 = value of new (0,0).
- rst for 1 cycle mid-row 3 -> all outputs 0 next cycle; restart without `frame_start` produces 24 correct windows.
- Boundary: no `window_valid` for any pixel with c<2 or r<2, checked across all 48 pixels.

Source files
------------

// File: rtl/window_3x3_gen_if.sv
// ----------------------------------------------------------------------------
// window_3x3_gen_if
//   Bundle between a raster pixel source and the 3x3 window producer.
//
//   Pixel stream (source -> producer):
//     pixel_valid   pixel_in is accepted this cycle (no backpressure)
//     pixel_in      PIXEL_WIDTH pixel, raster order
//     frame_start   with pixel_valid, marks the pixel as row 0 / col 0
//   Window results (producer -> consumer):
//     window_valid  window_flat holds a complete 3x3 window
//     window_flat   9 slots, slot k at [PIXEL_WIDTH*k +: PIXEL_WIDTH],
//                   k = 3*row + col, row 0 oldest, col 0 leftmost
//     frame_done    pulse with the last window of a frame
//     resync_err    pulse when frame_start arrives away from (0,0)
//
//   master: the pixel source / window consumer side.
//   slave : the window producer (window_3x3_gen).
// ----------------------------------------------------------------------------
interface window_3x3_gen_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                       pixel_valid;
    logic [PIXEL_WIDTH-1:0]     pixel_in;
    logic                       frame_start;
    logic                       window_valid;
    logic [PIXEL_WIDTH*9-1:0]   window_flat;
    logic                       frame_done;
    logic                       resync_err;

    modport master (
        output pixel_valid,
        output pixel_in,
        output frame_start,
        input  window_valid,
        input  window_flat,
        input  frame_done,
        input  resync_err
    );

    modport slave (
        input  pixel_valid,
        input  pixel_in,
        input  frame_start,
        output window_valid,
        output window_flat,
        output frame_done,
        output resync_err
    );
endinterface

// File: rtl/window_3x3_gen.sv
// ----------------------------------------------------------------------------
// window_3x3_gen
//   Turns a raster-order pixel stream into 3x3 windows, one per interior
//   pixel (row >= 2 and col >= 2), with a fixed two-cycle latency.
//   Two line buffers hold the previous two rows; a 3x3 shift register
//   assembles the window column by column.
//
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     bus   window_3x3_gen_if.slave: pixel stream in, window stream out
//
//   Pipeline:
//     cycle N    pixel accepted, position resolved, line buffers read
//     cycle N+1  stage 1 holds pixel, position, line-buffer read data
//     cycle N+2  stage 2 holds the shifted window and its qualifiers
// ----------------------------------------------------------------------------
module window_3x3_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int COL_BITS    = 10,
    parameter int ROW_BITS    = 9
) (
    input  logic               clk,
    input  logic               rst,
    window_3x3_gen_if.slave    bus
);

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);
    localparam logic [COL_BITS-1:0] COL_TWO  = COL_BITS'(2);
    localparam logic [ROW_BITS-1:0] ROW_TWO  = ROW_BITS'(2);

    // ------------------------------------------------------------------
    // Position tracking. col/row point at the position the next accepted
    // pixel will take; frame_start overrides that to (0,0).
    // ------------------------------------------------------------------
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] pos_col;
    logic [ROW_BITS-1:0] pos_row;
    logic                at_origin;

    assign at_origin = (col == '0) && (row == '0);

    always_comb begin
        pos_col = col;
        pos_row = row;
        if (bus.frame_start) begin
            pos_col = '0;
            pos_row = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.pixel_valid) begin
            if (pos_col == COL_LAST) begin
                col <= '0;
                if (pos_row == ROW_LAST)
                    row <= '0;
                else
                    row <= pos_row + ROW_BITS'(1);
            end else begin
                col <= pos_col + COL_BITS'(1);
                row <= pos_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers, one read port and one write port each, no reset.
    // lb1 holds row r-1, lb0 holds row r-2. lb1 is read and rewritten at
    // the same address in the same cycle (old data out). lb0 is refilled
    // one cycle later from the registered lb1 read, so only one read of
    // lb1 is needed per pixel.
    // ------------------------------------------------------------------
    logic [PIXEL_WIDTH-1:0] lb1_mem [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb0_mem [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1_rd;
    logic [PIXEL_WIDTH-1:0] lb0_rd;

    logic                   s1_valid;
    logic [PIXEL_WIDTH-1:0] s1_pix;
    logic [COL_BITS-1:0]    s1_col;
    logic [ROW_BITS-1:0]    s1_row;
    logic                   s1_byp;
    logic [PIXEL_WIDTH-1:0] s1_byp_data;
    logic                   resync_q;

    always_ff @(posedge clk) begin
        if (bus.pixel_valid && !rst) begin
            lb1_rd           <= lb1_mem[pos_col];
            lb0_rd           <= lb0_mem[pos_col];
            lb1_mem[pos_col] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid)
            lb0_mem[s1_col] <= lb1_rd;
    end

    // ------------------------------------------------------------------
    // Stage 1. The delayed lb0 write can target the very address being
    // read this cycle (a resync can land back on the column just
    // written); the bypass hands stage 2 the value that write carries so
    // lb0 keeps read-before-write semantics as seen from the window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_pix      <= '0;
            s1_col      <= '0;
            s1_row      <= '0;
            s1_byp      <= 1'b0;
            s1_byp_data <= '0;
            resync_q    <= 1'b0;
        end else begin
            s1_valid <= bus.pixel_valid;
            resync_q <= bus.pixel_valid && bus.frame_start && !at_origin;
            if (bus.pixel_valid) begin
                s1_pix      <= bus.pixel_in;
                s1_col      <= pos_col;
                s1_row      <= pos_row;
                s1_byp      <= s1_valid && (s1_col == pos_col);
                s1_byp_data <= lb1_rd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: shift the new column in from the right. Columns 0 and 1
    // of each row still shift (priming) but never raise window_valid, so
    // the previous row's tail never appears in an output window.
    // ------------------------------------------------------------------
    logic [PIXEL_WIDTH-1:0] win [9];
    logic [PIXEL_WIDTH-1:0] top_new;
    logic                   window_valid_q;
    logic                   frame_done_q;

    assign top_new = s1_byp ? s1_byp_data : lb0_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++)
                win[k] <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            window_valid_q <= s1_valid && (s1_row >= ROW_TWO) && (s1_col >= COL_TWO);
            frame_done_q   <= s1_valid && (s1_row == ROW_LAST) && (s1_col == COL_LAST);
            if (s1_valid) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= top_new;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= lb1_rd;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= s1_pix;
            end
        end
    end

    logic [PIXEL_WIDTH*9-1:0] flat;

    always_comb begin
        flat = '0;
        for (int k = 0; k < 9; k++)
            flat[PIXEL_WIDTH*k +: PIXEL_WIDTH] = win[k];
    end

    assign bus.window_valid = window_valid_q;
    assign bus.window_flat  = flat;
    assign bus.frame_done   = frame_done_q;
    assign bus.resync_err   = resync_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// ----------------------------------------------------------------------------
// tb_window_3x3_gen
//   Self-checking bench for window_3x3_gen on an 8x6 image. A reference
//   model keeps the image in a 2D array, tracks the frame position and
//   predicts every window (contents, frame_done) and resync pulse with its
//   due cycle; every cycle the DUT outputs are compared with it. Directed
//   frames add a table of fixed expected windows and count checks.
// ----------------------------------------------------------------------------
module tb_window_3x3_gen;

    localparam int PW  = 8;
    localparam int W   = 8;
    localparam int H   = 6;
    localparam int FW  = PW * 9;
    localparam int LOG = 4096;
    localparam int NT  = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_3x3_gen_if #(.PIXEL_WIDTH(PW)) bus ();

    window_3x3_gen #(
        .PIXEL_WIDTH (PW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .COL_BITS    (3),
        .ROW_BITS    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int              due;
        logic [FW-1:0]   flat;
        bit              done;
    } exp_t;

    typedef struct {
        int          r;
        int          c;
        bit          v;
        logic [7:0]  s0;
        logic [7:0]  s4;
        logic [7:0]  s8;
        bit          d;
    } rec_t;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    exp_t          wq[$];
    int            rq[$];
    logic [PW-1:0] img [H][W];
    int            pr = 0;
    int            pc = 0;
    int            acc [H][W];

    bit            obs_valid [LOG];
    logic [FW-1:0] obs_flat  [LOG];
    bit            obs_done  [LOG];

    int            win_cnt = 0;
    int            done_cnt = 0;
    int            rs_cnt = 0;
    logic [FW-1:0] seen[$];
    logic [FW-1:0] ref_list[$];
    rec_t          tbl [NT];

    function automatic logic [PW-1:0] slot(input logic [FW-1:0] f, input int k);
        return f[PW*k +: PW];
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cur);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cur);
        end
    endtask

    // One clock: drive inputs for cycle t, update the model with what the
    // DUT accepts, then compare the outputs of cycle t+1 with the model.
    task automatic step(input bit v, input logic [PW-1:0] p, input bit fs, input bit r);
        int   t;
        exp_t e;
        bit   exp_rs;
        bus.pixel_valid = v;
        bus.pixel_in    = p;
        bus.frame_start = fs;
        rst             = r;
        t = cur;
        @(posedge clk);
        #1;
        cur = t + 1;

        if (r) begin
            wq.delete();
            rq.delete();
            pr = 0;
            pc = 0;
        end else if (v) begin
            if (fs) begin
                if (pr != 0 || pc != 0)
                    rq.push_back(t + 1);
                pr = 0;
                pc = 0;
            end
            img[pr][pc] = p;
            acc[pr][pc] = t;
            if (pr >= 2 && pc >= 2) begin
                e.due  = t + 2;
                e.done = (pr == H - 1) && (pc == W - 1);
                e.flat = '0;
                for (int k = 0; k < 9; k++)
                    e.flat[PW*k +: PW] = img[pr - 2 + k / 3][pc - 2 + k % 3];
                wq.push_back(e);
            end
            pc++;
            if (pc == W) begin
                pc = 0;
                pr++;
                if (pr == H)
                    pr = 0;
            end
        end

        if (cur < LOG) begin
            obs_valid[cur] = bus.window_valid;
            obs_flat[cur]  = bus.window_flat;
            obs_done[cur]  = bus.frame_done;
        end

        if (wq.size() > 0 && wq[0].due == cur) begin
            e = wq.pop_front();
            chki("window_valid", int'(bus.window_valid), 1);
            chk("window_flat", bus.window_flat, e.flat);
            chki("frame_done", int'(bus.frame_done), int'(e.done));
        end else begin
            chki("window_valid", int'(bus.window_valid), 0);
            chki("frame_done", int'(bus.frame_done), 0);
        end

        exp_rs = (rq.size() > 0) && (rq[0] == cur);
        if (exp_rs)
            void'(rq.pop_front());
        chki("resync_err", int'(bus.resync_err), int'(exp_rs));

        if (bus.window_valid) begin
            win_cnt++;
            seen.push_back(bus.window_flat);
        end
        if (bus.frame_done)
            done_cnt++;
        if (bus.resync_err)
            rs_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic clear_stats();
        win_cnt  = 0;
        done_cnt = 0;
        rs_cnt   = 0;
        seen.delete();
    endtask

    initial begin
        int t;

        tbl[0] = '{2, 2, 1'b1, 8'h00, 8'h11, 8'h22, 1'b0};
        tbl[1] = '{3, 3, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0};
        tbl[2] = '{4, 6, 1'b1, 8'h24, 8'h35, 8'h46, 1'b0};
        tbl[3] = '{2, 7, 1'b1, 8'h05, 8'h16, 8'h27, 1'b0};
        tbl[4] = '{5, 7, 1'b1, 8'h35, 8'h46, 8'h57, 1'b1};
        tbl[5] = '{0, 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[6] = '{1, 7, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{3, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8] = '{5, 0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[9] = '{2, 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

        rst             = 1'b1;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        bus.frame_start = 1'b0;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("reset_flat", bus.window_flat, '0);
        idle(2);

        // Continuous frame, frame_start on first pixel
        clear_stats();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                step(1'b1, 8'(16 * r + c), (r == 0 && c == 0), 1'b0);
        idle(3);
        chki("t1_windows", win_cnt, 24);
        chki("t1_frame_done_count", done_cnt, 1);
        ref_list = seen;

        for (int i = 0; i < NT; i++) begin
            t = acc[tbl[i].r][tbl[i].c] + 2;
            chki($sformatf("tbl%0d_valid", i), int'(obs_valid[t]), int'(tbl[i].v));
            if (tbl[i].v) begin
                chki($sformatf("tbl%0d_slot0", i), int'(slot(obs_flat[t], 0)), int'(tbl[i].s0));
                chki($sformatf("tbl%0d_slot4", i), int'(slot(obs_flat[t], 4)), int'(tbl[i].s4));
                chki($sformatf("tbl%0d_slot8", i), int'(slot(obs_flat[t], 8)), int'(tbl[i].s8));
                chki($sformatf("tbl%0d_done", i), int'(obs_done[t]), int'(tbl[i].d));
            end
        end

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                chki($sformatf("boundary_r%0d_c%0d", r, c),
                     int'(obs_valid[acc[r][c] + 2]), int'(r >= 2 && c >= 2));

        // Same frame with random idle gaps
        clear_stats();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                for (int g = 0; g < 6 && $urandom_range(0, 99) < 40; g++)
                    step(1'b0, 8'($urandom), 1'b0, 1'b0);
                step(1'b1, 8'(16 * r + c), (r == 0 && c == 0), 1'b0);
            end
        idle(3);
        chki("t2_windows", win_cnt, 24);
        chki("t2_frame_done_count", done_cnt, 1);
        for (int i = 0; i < 24; i++)
            if (i < seen.size() && i < ref_list.size())
                chk($sformatf("t2_order_%0d", i), seen[i], ref_list[i]);

        // Two back-to-back frames, second offset by 0x80
        clear_stats();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    step(1'b1, 8'(128 * f + 16 * r + c), (r == 0 && c == 0), 1'b0);
        idle(3);
        chki("t3_windows", win_cnt, 48);
        chki("t3_frame_done_count", done_cnt, 2);
        chki("t3_resync_count", rs_cnt, 0);
        if (seen.size() > 24) begin
            chki("t3_f2_slot0", int'(slot(seen[24], 0)), 8'h80);
            chki("t3_f2_slot8", int'(slot(seen[24], 8)), 8'hA2);
        end else begin
            chki("t3_f2_present", seen.size(), 25);
        end

        // frame_start at (3,4) of a running frame
        clear_stats();
        for (int i = 0; i < 3 * W + 4; i++)
            step(1'b1, 8'(16 * (i / W) + (i % W)), (i == 0), 1'b0);
        for (int i = 0; i < W * H; i++)
            step(1'b1, 8'(8'hC0 + 16 * (i / W) + (i % W)), (i == 0), 1'b0);
        idle(3);
        chki("t4_resync_count", rs_cnt, 1);
        chki("t4_windows", win_cnt, 8 + 24);
        if (seen.size() > 8) begin
            chki("t4_new_slot0", int'(slot(seen[8], 0)), 8'hC0);
            chki("t4_new_slot8", int'(slot(seen[8], 8)), 8'hE2);
        end else begin
            chki("t4_new_present", seen.size(), 9);
        end

        // Reset mid row 3 (frame_start asserted with it: reset wins)
        clear_stats();
        for (int i = 0; i < 3 * W + 4; i++)
            step(1'b1, 8'(16 * (i / W) + (i % W)), (i == 0), 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        chki("t5_rst_valid", int'(bus.window_valid), 0);
        chk("t5_rst_flat", bus.window_flat, '0);
        chki("t5_rst_done", int'(bus.frame_done), 0);
        chki("t5_rst_resync", int'(bus.resync_err), 0);
        clear_stats();
        for (int i = 0; i < W * H; i++)
            step(1'b1, 8'(16 * (i / W) + (i % W)), 1'b0, 1'b0);
        idle(3);
        chki("t5_windows", win_cnt, 24);
        chki("t5_frame_done_count", done_cnt, 1);
        chki("t5_resync_count", rs_cnt, 0);

        // Random pixels, gaps and occasional stray frame_start
        for (int i = 0; i < 3 * W * H; i++) begin
            for (int g = 0; g < 4 && $urandom_range(0, 99) < 30; g++)
                step(1'b0, 8'($urandom), 1'($urandom), 1'b0);
            step(1'b1, 8'($urandom), (i % (W * H) == 0) || ($urandom_range(0, 49) == 0), 1'b0);
        end
        idle(3);
        chki("t6_pending_windows", wq.size(), 0);
        chki("t6_pending_resync", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
